// File: rtl/peripheral_bcd7seg.sv
// peripheral_bcd7seg: double-buffered BCD 7-segment scan driver; define BCD7SEG_HEX_EN for hex glyphs on codes 10-15
module peripheral_bcd7seg #(
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       d_in,
  input  logic              cs,
  input  logic [4:0]        addr,
  input  logic              rd,
  input  logic              wr,
  output logic [31:0]       d_out,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int W = 4 * DIGITS;
  logic [W-1:0] stg, act, act_n;
  logic [DIGITS-1:0] dps, dpa, dpa_n;
  logic en, lz, pend, en_n, lz_n, pend_n;
  logic [PW-1:0] pre, pre_n;
  logic [2:0] idx, idx_n;
  logic we, wc, last, fe, go, z, blank;
  logic [3:0] code;
  logic [6:0] seg_n;
  logic [31:0] rdata;

  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
`ifdef BCD7SEG_HEX_EN
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
`else
      default: return 7'h7F;
`endif
    endcase
  endfunction

  // next-state: scan position, commit of staging into the active set, glyph with leading-zero blanking
  always_comb begin
    we = cs && wr;
    wc = we && addr == 5'h14;
    last = pre == PW'(SCAN_DIV - 1);
    fe = en && last && idx == 3'(DIGITS - 1);
    go = pend && !wc && (fe || !en);
    en_n = (we && addr == 5'h10) ? d_in[0] : en;
    lz_n = (we && addr == 5'h10) ? d_in[1] : lz;
    pend_n = wc || (pend && !go);
    act_n = go ? stg : act;
    dpa_n = go ? dps : dpa;
    pre_n = (en && en_n && !last) ? pre + 1'b1 : '0;
    idx_n = !(en && en_n) ? 3'd0 : !last ? idx : idx == 3'(DIGITS - 1) ? 3'd0 : idx + 3'd1;
    code = act_n[4*idx_n +: 4];
    z = 1'b1;
    blank = 1'b0;
    for (int j = DIGITS - 1; j > 0; j--) begin
      z = z && (act_n[4*j +: 4] == 4'd0);
      if (idx_n == 3'(j)) blank = lz_n && z;
    end
    seg_n = blank ? 7'h7F : dec(code);
    rdata = addr == 5'h04 ? 32'(stg[15:0]) :
            addr == 5'h08 ? 32'(stg[W-1:16]) :
            addr == 5'h0C ? 32'(dps) :
            addr == 5'h10 ? {30'd0, lz, en} :
            addr == 5'h18 ? {23'd0, pend, 5'd0, idx} : 32'd0;
  end

  // registers, bus writes/reads, and display outputs aligned with the scan index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg <= '0;
      act <= '0;
      dps <= '0;
      dpa <= '0;
      en <= 1'b0;
      lz <= 1'b0;
      pend <= 1'b0;
      pre <= '0;
      idx <= 3'd0;
      d_out <= 32'd0;
      an <= '1;
      seg <= 7'h7F;
      dp <= 1'b1;
    end else begin
      if (we && addr == 5'h04) stg[15:0] <= d_in;
      if (we && addr == 5'h08) stg[W-1:16] <= d_in[W-17:0];
      if (we && addr == 5'h0C) dps <= d_in[DIGITS-1:0];
      if (cs && rd) d_out <= rdata;
      act <= act_n;
      dpa <= dpa_n;
      en <= en_n;
      lz <= lz_n;
      pend <= pend_n;
      pre <= pre_n;
      idx <= idx_n;
      an <= en_n ? ~(DIGITS'(1) << idx_n) : '1;
      seg <= en_n ? seg_n : 7'h7F;
      dp <= !(en_n && dpa_n[idx_n]);
    end
  end
endmodule

// File: tb/tb_peripheral_bcd7seg.sv
// tb_peripheral_bcd7seg: randomized scoreboard bench for peripheral_bcd7seg
module tb_peripheral_bcd7seg;
  localparam int D = 5;
  localparam int SD = 4;
  localparam int P = D * SD;

  typedef struct packed {
    logic [4:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [31:0] dout;
  } exp_t;

  logic clk = 1'b0, reset = 1'b0, cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [4:0] addr = 5'd0;
  logic [15:0] d_in = 16'd0;
  logic [31:0] d_out;
  logic [6:0] seg;
  logic dp;
  logic [D-1:0] an;

  int checks = 0, errors = 0;
  exp_t sb[$];
  int m_stg[D], m_act[D];
  int m_dps, m_dpa, m_en, m_lz, m_pend, m_t;
  logic [31:0] m_dout;

  always #5 clk = ~clk;

  peripheral_bcd7seg #(.DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .seg(seg), .dp(dp), .an(an)
  );

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
`ifdef BCD7SEG_HEX_EN
      10: return 7'h08;
      11: return 7'h03;
      12: return 7'h46;
      13: return 7'h21;
      14: return 7'h06;
      default: return 7'h0E;
`else
      default: return 7'h7F;
`endif
    endcase
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int k;
    bit blank;
    e.dout = m_dout;
    if (!m_en) begin
      e.an = 5'h1F;
      e.seg = 7'h7F;
      e.dp = 1'b1;
      return e;
    end
    k = m_t / SD;
    blank = m_lz != 0 && k > 0;
    for (int j = k; j < D; j++) if (m_act[j] != 0) blank = 0;
    e.an = 5'(32'h1F & ~(1 << k));
    e.seg = blank ? 7'h7F : glyph(m_act[k]);
    e.dp = ((m_dpa >> k) & 1) == 0;
    return e;
  endfunction

  function automatic logic [31:0] rd_model(input int k);
    case (addr)
      5'h04: return 32'((m_stg[3] << 12) | (m_stg[2] << 8) | (m_stg[1] << 4) | m_stg[0]);
      5'h08: return 32'(m_stg[4]);
      5'h0C: return 32'(m_dps);
      5'h10: return 32'(m_lz * 2 + m_en);
      5'h18: return 32'(m_pend * 256 + k);
      default: return 32'd0;
    endcase
  endfunction

  // reference model: digit slot = (cycles since enable / SCAN_DIV) mod DIGITS
  initial begin : model
    int k, ne;
    bit go, wc;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int i = 0; i < D; i++) begin
          m_stg[i] = 0;
          m_act[i] = 0;
        end
        m_dps = 0; m_dpa = 0; m_en = 0; m_lz = 0; m_pend = 0; m_t = 0; m_dout = 32'd0;
        sb.delete();
        sb.push_back(expect_now());
      end else begin
        k = m_t / SD;
        wc = cs && wr && addr == 5'h14;
        if (cs && rd) m_dout = rd_model(k);
        go = m_pend != 0 && !wc && (m_en == 0 || m_t == P - 1);
        if (go) begin
          m_act = m_stg;
          m_dpa = m_dps;
          m_pend = 0;
        end
        ne = (cs && wr && addr == 5'h10) ? int'(d_in[0]) : m_en;
        m_t = (m_en != 0 && ne != 0) ? (m_t + 1) % P : 0;
        if (cs && wr) begin
          case (addr)
            5'h04: for (int i = 0; i < 4; i++) m_stg[i] = (int'(d_in) >> (4 * i)) & 15;
            5'h08: m_stg[4] = int'(d_in[3:0]);
            5'h0C: m_dps = int'(d_in[4:0]);
            5'h10: begin m_en = int'(d_in[0]); m_lz = int'(d_in[1]); end
            5'h14: m_pend = 1;
            default: ;
          endcase
        end
        sb.push_back(expect_now());
      end
    end
  end

  // monitor: pops one expectation per cycle; also checks outputs right after an asynchronous reset
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or negedge reset);
      if (clk) begin
        #1;
        checks++;
        if ({an, seg, dp, d_out} !== {5'h1F, 7'h7F, 1'b1, 32'd0}) begin
          errors++;
          $display("FAIL async_reset an=%h seg=%h dp=%b d_out=%h want an=1f seg=7f dp=1 d_out=0", an, seg, dp, d_out);
        end
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({an, seg, dp, d_out} !== e) begin
          errors++;
          $display("FAIL scan @%0t an=%h seg=%h dp=%b d_out=%h want an=%h seg=%h dp=%b d_out=%h",
                   $time, an, seg, dp, d_out, e.an, e.seg, e.dp, e.dout);
        end
      end
    end
  end

  task automatic bus(input logic w, input logic r, input logic [4:0] a, input logic [15:0] d);
    cs = 1'b1; wr = w; rd = r; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic wrr(input logic [4:0] a, input logic [15:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rdr(input logic [4:0] a);
    bus(1'b0, 1'b1, a, 16'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    int k = 0;
    while (!(m_en != 0 && m_t == P - 1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      $display("FAIL align_timeout no frame end within 200 cycles");
      $fatal(1);
    end
  endtask

  initial begin : stim
    logic [4:0] regs[8];
    logic [15:0] d;
    regs = '{5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h00, 5'h1C};
    idle(3);
    reset = 1'b1;
    rdr(5'h18);
    wrr(5'h04, 16'h4321); wrr(5'h08, 16'h0005); wrr(5'h10, 16'h1); wrr(5'h14, 16'h0);
    idle(2 * P + 5);
    rdr(5'h18);
    wrr(5'h04, 16'h0042); wrr(5'h08, 16'h0); wrr(5'h10, 16'h3); wrr(5'h14, 16'h0);
    idle(2 * P + 5);
    wrr(5'h04, 16'h0000); wrr(5'h14, 16'h0);
    idle(2 * P + 5);
    wrr(5'h10, 16'h1); wrr(5'h04, 16'h4321); wrr(5'h14, 16'h0);
    idle(2 * P + 5);
    wrr(5'h04, 16'h9999);
    idle(P + 3);
    align();
    wrr(5'h14, 16'h0);
    rdr(5'h18);
    idle(2 * P + 5);
    wrr(5'h04, 16'h000A); wrr(5'h0C, 16'h0002); wrr(5'h14, 16'h0);
    idle(2 * P + 5);
    rdr(5'h0C); rdr(5'h10); rdr(5'h04); rdr(5'h08); rdr(5'h1C);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          addr = regs[$urandom_range(0, 7)];
          d = 16'($urandom);
          if (addr == 5'h10 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
          wrr(addr, d);
        end
        2: rdr(regs[$urandom_range(0, 7)]);
        default: idle(1);
      endcase
    end
    wrr(5'h10, 16'h1); wrr(5'h04, 16'h1234);
    align();
    idle(2);
    wrr(5'h14, 16'h0);
    idle(4);
    @(posedge clk);
    #2 reset = 1'b0;
    idle(2);
    reset = 1'b1;
    rdr(5'h18);
    wrr(5'h10, 16'h1);
    idle(10);
    wrr(5'h10, 16'h0);
    rdr(5'h18);
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
